// File: rtl/modulo_varredura_1_16.sv
// Scan generator: steps a 1:16 demux channel index, holding each for DWELL cycles, with 4x4 window coordinates.
// Optional macro VARREDURA_CONTINUOUS_EN: repeat frames back to back, pulsing done at each wrap.
module modulo_varredura_1_16 #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] col_base,
  input  logic [2:0] row_base,
  output logic [3:0] dmx16_sel,
  output logic [2:0] mdc,
  output logic [2:0] mdl,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    DONE_S = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     state, state_nx;
  logic [3:0] idx;
  logic [7:0] cnt;
  logic [2:0] col_l, row_l;
  logic       expire;
  logic       last_ch;

  assign expire  = (cnt == LAST);
  assign last_ch = (idx == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = SHOW;
      SHOW: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (expire && last_ch) begin
`ifdef VARREDURA_CONTINUOUS_EN
          state_nx = SHOW;
`else
          state_nx = DONE_S;
`endif
        end
      end
      DONE_S: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // idx wraps 15 -> 0 by its own width, which parks it at 0 after a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= 4'd0;
      cnt   <= 8'd0;
      col_l <= 3'd0;
      row_l <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            col_l <= col_base;
            row_l <= row_base;
            idx   <= 4'd0;
            cnt   <= 8'd0;
          end
        end
        SHOW: begin
          if (stop) begin
            idx <= 4'd0;
            cnt <= 8'd0;
          end else if (expire) begin
            idx <= idx + 4'd1;
            cnt <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          idx <= idx;
          cnt <= cnt;
        end
      endcase
    end
  end

`ifdef VARREDURA_CONTINUOUS_EN
  logic done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= (state == SHOW) && !stop && expire && last_ch;
  end
`endif

  always_comb begin
    valid     = (state == SHOW);
    busy      = (state != IDLE);
`ifdef VARREDURA_CONTINUOUS_EN
    done      = done_q;
`else
    done      = (state == DONE_S);
`endif
    dmx16_sel = idx;
    mdc       = col_l + {1'b0, idx[1:0]};
    mdl       = row_l + {1'b0, idx[3:2]};
  end

endmodule

// File: tb/tb_modulo_varredura_1_16.sv
// Directed bench: instance a (DWELL=4, or 2 in continuous builds) and instance b (DWELL=1).
`timescale 1ns/1ps
module tb_modulo_varredura_1_16;

`ifdef VARREDURA_CONTINUOUS_EN
  localparam int DA = 2;
`else
  localparam int DA = 4;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, stop = 1'b0;
  logic [2:0] col_base = 3'd0, row_base = 3'd0;
  logic [3:0] sel_a, sel_b;
  logic [2:0] mdc_a, mdl_a, mdc_b, mdl_b;
  logic       valid_a, busy_a, done_a, valid_b, busy_b, done_b;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  modulo_varredura_1_16 #(.DWELL(DA)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stop(stop),
    .col_base(col_base), .row_base(row_base),
    .dmx16_sel(sel_a), .mdc(mdc_a), .mdl(mdl_a),
    .valid(valid_a), .busy(busy_a), .done(done_a)
  );

  modulo_varredura_1_16 #(.DWELL(1)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop),
    .col_base(col_base), .row_base(row_base),
    .dmx16_sel(sel_b), .mdc(mdc_b), .mdl(mdl_b),
    .valid(valid_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_sel"},   32'(sel_a),   32'd0);
    check({tag, "_mdc"},   32'(mdc_a),   32'd0);
    check({tag, "_mdl"},   32'(mdl_a),   32'd0);
    check({tag, "_valid"}, 32'(valid_a), 32'd0);
    check({tag, "_busy"},  32'(busy_a),  32'd0);
    check({tag, "_done"},  32'(done_a),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_done;

    // reset state before any clock edge
    #3;
    check_a_zero("rst");
    check("rst_b_valid", 32'(valid_b), 32'd0);
    check("rst_b_sel",   32'(sel_b),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("idle_valid", 32'(valid_a), 32'd0);
      check("idle_busy",  32'(busy_a),  32'd0);
      check("idle_sel",   32'(sel_a),   32'd0);
    end

    // wrap arithmetic on instance b, DWELL=1, bases 6/7
    col_base = 3'd6; row_base = 3'd7; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    col_base = 3'd1; row_base = 3'd1;
    for (int k = 0; k < 16; k++) begin
      check("b_valid", 32'(valid_b), 32'd1);
      check("b_sel",   32'(sel_b),   32'(k));
      check("b_mdc",   32'(mdc_b),   32'((6 + k % 4) % 8));
      check("b_mdl",   32'(mdl_b),   32'((7 + k / 4) % 8));
      if (k == 3) begin
        check("b_idx3_mdc", 32'(mdc_b), 32'd1);
        check("b_idx3_mdl", 32'(mdl_b), 32'd7);
      end
      if (k == 14) begin
        check("b_idx14_mdc", 32'(mdc_b), 32'd0);
        check("b_idx14_mdl", 32'(mdl_b), 32'd2);
      end
      tick();
    end
`ifndef VARREDURA_CONTINUOUS_EN
    check("b_done", 32'(done_b), 32'd1);
    check("b_done_busy", 32'(busy_b), 32'd1);
    check("b_done_valid", 32'(valid_b), 32'd0);
    tick();
    check("b_done_fall", 32'(done_b), 32'd0);
    check("b_busy_fall", 32'(busy_b), 32'd0);

    // single frame, DWELL=4, bases 0/0
    col_base = 3'd0; row_base = 3'd0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 64; k++) begin
      check("f_valid", 32'(valid_a), 32'd1);
      check("f_busy",  32'(busy_a),  32'd1);
      check("f_done",  32'(done_a),  32'd0);
      check("f_sel",   32'(sel_a),   32'(k / 4));
      check("f_mdc",   32'(mdc_a),   32'((k / 4) % 4));
      check("f_mdl",   32'(mdl_a),   32'((k / 4) / 4));
      if (k == 20) begin
        check("f_idx5_mdc", 32'(mdc_a), 32'd1);
        check("f_idx5_mdl", 32'(mdl_a), 32'd1);
      end
      tick();
    end
    check("f_end_done",  32'(done_a),  32'd1);
    check("f_end_valid", 32'(valid_a), 32'd0);
    check("f_end_busy",  32'(busy_a),  32'd1);
    tick();
    check("f_post_done", 32'(done_a), 32'd0);
    check("f_post_busy", 32'(busy_a), 32'd0);

    // earliest restart right after done, then abort at idx 9 with an ignored start at idx 2
    col_base = 3'd2; row_base = 3'd3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 36; k++) begin
      check("ab_sel", 32'(sel_a), 32'(k / 4));
      check("ab_mdc", 32'(mdc_a), 32'((2 + (k / 4) % 4) % 8));
      check("ab_mdl", 32'(mdl_a), 32'((3 + (k / 4) / 4) % 8));
      start_a = (k == 8);
      tick();
    end
    start_a = 1'b0;
    check("ab_idx9", 32'(sel_a), 32'd9);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("ab_valid", 32'(valid_a), 32'd0);
    check("ab_busy",  32'(busy_a),  32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 80; k++) begin
      saw_done |= done_a;
      tick();
    end
    check("ab_no_done", 32'(saw_done), 32'd0);

    // reset mid-scan at idx 7, then restart with new bases
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (28) tick();
    check("mr_idx7", 32'(sel_a), 32'd7);
    #2 reset = 1'b1;
    #1;
    check_a_zero("mr");
    @(negedge clk);
    reset = 1'b0;
    col_base = 3'd5; row_base = 3'd4; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("rs_sel",   32'(sel_a),   32'd0);
    check("rs_mdc",   32'(mdc_a),   32'd5);
    check("rs_mdl",   32'(mdl_a),   32'd4);
    check("rs_valid", 32'(valid_a), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("rs_stop", 32'(valid_a), 32'd0);
`else
    // continuous scan on instance a, DWELL=2
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("b_stop", 32'(valid_b), 32'd0);
    col_base = 3'd0; row_base = 3'd0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 97; k++) begin
      check("c_valid", 32'(valid_a), 32'd1);
      check("c_sel",   32'(sel_a),   32'((k / 2) % 16));
      check("c_done",  32'(done_a),  32'((k > 0 && k % 32 == 0) ? 1 : 0));
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("c_stop_valid", 32'(valid_a), 32'd0);
    check("c_stop_busy",  32'(busy_a),  32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/modulo_varredura_1_16.md
# modulo_varredura_1_16

Sequential scan generator driving the 1:16 demultiplexer select path of the display. It works in the opposite direction from the coordinate-to-select decoder. It steps a channel index through 0..15, holds each channel for a fixed number of clock cycles, and emits both the demux select and the matching column/row coordinates (mdc/mdl) of a 4x4 window placed anywhere on the 8x8 coordinate space. It sits between the display controller, which uses the start/stop/done handshake, and the demux/coordinate consumers.

## Interface
- DWELL, default 4: clock cycles each channel is held; legal range 1..255.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous reset, active-high.
- start  input  1  request a scan; sampled only in IDLE.
- stop  input  1  abort the current scan; sampled in SHOW.
- col_base  input  3  window column origin; latched on accepted start.
- row_base  input  3  window row origin; latched on accepted start.
- dmx16_sel  output  4  current channel index.
- mdc  output  3  column coordinate of the current channel.
- mdl  output  3  row coordinate of the current channel.
- valid  output  1  high while dmx16_sel/mdc/mdl describe a live channel.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a completed frame.

## Operation
- States:
  - IDLE: outputs parked.
  - SHOW: channel displayed; dwell counter running.
  - DONE: single cycle.
- IDLE -> SHOW when start=1:
  - latch col_base/row_base;
  - idx <= 0;
  - dwell counter <= 0.
- In SHOW, the dwell counter increments each cycle. On the cycle where the counter equals DWELL-1:
  - if idx != 15: idx <= idx+1 and counter <= 0;
  - if idx == 15: go to DONE (or wrap; see Configuration).
- SHOW -> IDLE when stop=1. Stop has priority over dwell expiry. No done pulse is produced.
- DONE -> IDLE unconditionally after one cycle.
- start while busy=1 is ignored; it is not queued.
- Coordinate arithmetic is modulo 8, carries discarded:
  - mdc = col_l + {1'b0, idx[1:0]};
  - mdl = row_l + {1'b0, idx[3:2]}.
- dmx16_sel = idx. Channel order is row-major within the window: idx 0..3 is row 0, columns 0..3.
- col_base/row_base changes during a scan have no effect until the next accepted start.
- valid = 1 only in SHOW. busy = 1 in SHOW and DONE. done = 1 only in DONE.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Timing
- Reset: state=IDLE; idx, dwell counter, latched bases, dmx16_sel, mdc and mdl = 0; valid=busy=done=0.
- Reset asserted mid-scan returns the block to IDLE immediately, without waiting for a clock edge. No done pulse is produced.
- start is sampled at edge N. From edge N onward: valid=1, busy=1, dmx16_sel=0.
- Each channel is visible for exactly DWELL cycles. A frame occupies 16*DWELL cycles in SHOW.
- done is high during the single cycle following the last SHOW cycle. busy falls together with done.
- Earliest restart: start sampled in the cycle after done, giving a 2-cycle gap between frames (DONE, IDLE).
- DWELL=1: idx advances every cycle. The dwell counter never leaves 0.
- stop sampled at edge M: from edge M, state=IDLE and valid=busy=0.

## Configuration
- VARREDURA_CONTINUOUS_EN:
  - Defined: at idx 15 with dwell expiry, the block pulses done for one cycle while staying in SHOW, with idx <= 0. Scanning repeats indefinitely, with no gap between frames, until stop or reset. valid stays high across the wrap. The DONE state is unused.
  - Undefined: single-frame behaviour as specified above.

## Test plan
- Reset: assert reset mid-cycle with no clock -> all outputs 0 immediately. Release, hold start=0 for 10 cycles -> outputs remain 0.
- Single frame, DWELL=4, col_base=0, row_base=0, start one cycle:
  - dmx16_sel steps 0..15, each held 4 cycles, 64 valid cycles total;
  - at idx 5: mdc=1, mdl=1;
  - done pulses once, 1 cycle after the last valid cycle.
- Wrap: col_base=6, row_base=7, DWELL=1:
  - idx 3 -> mdc=1, mdl=7;
  - idx 14 -> mdc=0, mdl=2.
- Abort and ignored start:
  - stop at idx 9 -> next edge valid=0, busy=0, and done never asserts;
  - start pulsed during the scan is ignored (idx continues without restarting).
- Reset mid-scan at idx 7 -> immediate IDLE with all outputs 0. A new start afterwards begins at idx 0 with newly latched bases.
- With VARREDURA_CONTINUOUS_EN, DWELL=2:
  - done pulses every 32 cycles;
  - dmx16_sel goes 15 -> 0 without valid dropping;
  - stop ends the scan.
